// File: rtl/phase_checker.sv
// Receive-side monitor for the CPU phase lines.
// Locks onto the rotation decode -> exec -> rdmem -> fetch -> decode, flags
// protocol violations with a sticky error that records the offending vector,
// counts completed instruction cycles and pulses once per accepted decode.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   phase_decode phase line, vector bit 3
//   phase_exec   phase line, vector bit 2
//   phase_rdmem  phase line, vector bit 1
//   phase_fetch  phase line, vector bit 0
//   clr_err      level; leaves ERROR back to SYNC
//   locked       high while locked onto the rotation
//   err          high while in ERROR
//   err_code     1 = not one-hot, 2 = out of order, 3 = sync timeout, 0 = none
//   err_phases   phase vector that caused the error
//   insn_count   completed instruction cycles, wraps modulo 2^CNT_WIDTH
//   cycle_start  one-cycle pulse after each accepted decode sample
module phase_checker #(
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned LOCK_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 phase_decode,
  input  logic                 phase_exec,
  input  logic                 phase_rdmem,
  input  logic                 phase_fetch,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [3:0]           err_phases,
  output logic [CNT_WIDTH-1:0] insn_count,
  output logic                 cycle_start
);

  localparam int unsigned PV_W   = 4;
  localparam int unsigned TMR_W  = 8;
  localparam int unsigned CODE_W = 2;

  localparam logic [PV_W-1:0]   PV_DECODE = 4'b1000;
  localparam logic [PV_W-1:0]   PV_EXEC   = 4'b0100;
  localparam logic [PV_W-1:0]   PV_FETCH  = 4'b0001;

  localparam logic [CODE_W-1:0] CODE_NONE    = 2'd0;
  localparam logic [CODE_W-1:0] CODE_ONEHOT  = 2'd1;
  localparam logic [CODE_W-1:0] CODE_ORDER   = 2'd2;
  localparam logic [CODE_W-1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PV_W-1:0]      exp_q, exp_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic [CODE_W-1:0]    err_code_q, err_code_d;
  logic [PV_W-1:0]      err_phases_q, err_phases_d;
  logic [CNT_WIDTH-1:0] insn_count_q, insn_count_d;
  logic                 cycle_start_q, cycle_start_d;

  logic [PV_W-1:0]      pv;
  logic                 pv_valid;

  // Sampled phase vector; valid only when exactly one line is high.
  assign pv       = {phase_decode, phase_exec, phase_rdmem, phase_fetch};
  assign pv_valid = $onehot(pv);

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_SYNC;
      exp_q         <= PV_DECODE;
      timer_q       <= '0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= CODE_NONE;
      err_phases_q  <= '0;
      insn_count_q  <= '0;
      cycle_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      timer_q       <= timer_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      err_phases_q  <= err_phases_d;
      insn_count_q  <= insn_count_d;
      cycle_start_q <= cycle_start_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    timer_d       = timer_q;
    err_code_d    = err_code_q;
    err_phases_d  = err_phases_q;
    insn_count_d  = insn_count_q;
    cycle_start_d = 1'b0;

    unique case (state_q)
      ST_SYNC: begin
        if (!pv_valid) begin
          state_d      = ST_ERROR;
          err_code_d   = CODE_ONEHOT;
          err_phases_d = pv;
        end else if (pv == PV_DECODE) begin
          state_d       = ST_LOCKED;
          exp_d         = PV_EXEC;
          cycle_start_d = 1'b1;
          timer_d       = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_d == TMR_W'(LOCK_TIMEOUT)) begin
            state_d      = ST_ERROR;
            err_code_d   = CODE_TIMEOUT;
            err_phases_d = pv;
          end
        end
      end

      ST_LOCKED: begin
        if (!pv_valid) begin
          state_d      = ST_ERROR;
          err_code_d   = CODE_ONEHOT;
          err_phases_d = pv;
        end else if (pv != exp_q) begin
          state_d      = ST_ERROR;
          err_code_d   = CODE_ORDER;
          err_phases_d = pv;
        end else begin
          // Rotate right with wrap: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
          exp_d = {exp_q[0], exp_q[PV_W-1:1]};
          if (pv == PV_FETCH) begin
            insn_count_d = insn_count_q + CNT_WIDTH'(1);
          end
          if (pv == PV_DECODE) begin
            cycle_start_d = 1'b1;
          end
        end
      end

      ST_ERROR: begin
        // Phase lines are ignored here, so a decode on the clearing edge is not accepted.
        if (clr_err) begin
          state_d      = ST_SYNC;
          err_code_d   = CODE_NONE;
          err_phases_d = '0;
          timer_d      = '0;
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
    err_d    = (state_d == ST_ERROR);
  end

  assign locked      = locked_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign err_phases  = err_phases_q;
  assign insn_count  = insn_count_q;
  assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_phase_checker.sv
// Scoreboard bench for phase_checker: each stimulus step pushes the outputs
// expected after the next rising edge; a monitor pops and compares them
// shortly after every rising edge while reset is released.
module tb_phase_checker;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic          l;
    logic          e;
    logic [1:0]    code;
    logic [3:0]    ph;
    logic [CW-1:0] cnt;
    logic          cs;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [3:0]    pv;
  logic          clr;
  logic          locked;
  logic          err;
  logic [1:0]    err_code;
  logic [3:0]    err_phases;
  logic [CW-1:0] insn_count;
  logic          cycle_start;

  exp_t q[$];
  int   n_checks;
  int   n_fails;

  phase_checker #(
    .CNT_WIDTH   (CW),
    .LOCK_TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .phase_decode(pv[3]),
    .phase_exec  (pv[2]),
    .phase_rdmem (pv[1]),
    .phase_fetch (pv[0]),
    .clr_err     (clr),
    .locked      (locked),
    .err         (err),
    .err_code    (err_code),
    .err_phases  (err_phases),
    .insn_count  (insn_count),
    .cycle_start (cycle_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic l, input logic e, input logic [1:0] code,
                              input logic [3:0] ph, input logic [CW-1:0] cnt,
                              input logic cs);
    exp_t x;
    x.l = l; x.e = e; x.code = code; x.ph = ph; x.cnt = cnt; x.cs = cs;
    return x;
  endfunction

  function automatic exp_t actual();
    return mk(locked, err, err_code, err_phases, insn_count, cycle_start);
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got locked=%b err=%b code=%0d phases=%b count=%0d cs=%b, required locked=%b err=%b code=%0d phases=%b count=%0d cs=%b",
               name, act.l, act.e, act.code, act.ph, act.cnt, act.cs,
               req.l, req.e, req.code, req.ph, req.cnt, req.cs);
    end
  endtask

  // Monitor: outputs are presented every cycle once reset is released.
  always @(posedge clk) begin
    #1;
    if (rst && q.size() > 0) begin
      exp_t req;
      req = q.pop_front();
      compare("cycle", actual(), req);
    end
  end

  // Drive one phase sample and queue the outputs expected after it is taken.
  task automatic step(input logic [3:0] v, input logic c, input logic l, input logic e,
                      input logic [1:0] code, input logic [3:0] ph,
                      input logic [CW-1:0] cnt, input logic cs);
    @(negedge clk);
    pv  = v;
    clr = c;
    q.push_back(mk(l, e, code, ph, cnt, cs));
  endtask

  initial begin
    logic [CW-1:0] c;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    pv  = 4'b1000;
    clr = 1'b0;

    #12;
    compare("reset_values", actual(), mk(0, 0, 2'd0, 4'b0000, 4'd0, 0));
    #1;
    rst = 1'b1;
    // Decode sampled at the first edge after release.
    q.push_back(mk(1, 0, 2'd0, 4'b0000, 4'd0, 1));

    // Full rotation then the next decode.
    step(4'b0100, 0, 1, 0, 2'd0, 4'b0000, 4'd0, 0);
    step(4'b0010, 0, 1, 0, 2'd0, 4'b0000, 4'd0, 0);
    step(4'b0001, 0, 1, 0, 2'd0, 4'b0000, 4'd1, 0);
    step(4'b1000, 0, 1, 0, 2'd0, 4'b0000, 4'd1, 1);
    // Out of order: expecting 0010, see 0001.
    step(4'b0100, 0, 1, 0, 2'd0, 4'b0000, 4'd1, 0);
    step(4'b0001, 0, 0, 1, 2'd2, 4'b0001, 4'd1, 0);
    // Sticky: phases ignored in ERROR.
    step(4'b1000, 0, 0, 1, 2'd2, 4'b0001, 4'd1, 0);
    // Clear; decode on the clearing edge is not accepted.
    step(4'b1000, 1, 0, 0, 2'd0, 4'b0000, 4'd1, 0);
    step(4'b1000, 0, 1, 0, 2'd0, 4'b0000, 4'd1, 1);
    step(4'b0100, 0, 1, 0, 2'd0, 4'b0000, 4'd1, 0);
    step(4'b0010, 0, 1, 0, 2'd0, 4'b0000, 4'd1, 0);
    step(4'b0001, 0, 1, 0, 2'd0, 4'b0000, 4'd2, 0);
    step(4'b1000, 0, 1, 0, 2'd0, 4'b0000, 4'd2, 1);
    // Multi-bit vector while locked.
    step(4'b0110, 0, 0, 1, 2'd1, 4'b0110, 4'd2, 0);
    step(4'b0000, 1, 0, 0, 2'd0, 4'b0000, 4'd2, 0);
    step(4'b1000, 0, 1, 0, 2'd0, 4'b0000, 4'd2, 1);
    // All-zero vector while locked.
    step(4'b0000, 0, 0, 1, 2'd1, 4'b0000, 4'd2, 0);
    step(4'b0100, 1, 0, 0, 2'd0, 4'b0000, 4'd2, 0);
    // Sync timeout: 8th valid non-decode sample errors.
    for (int i = 1; i <= 7; i++) step(4'b0100, 0, 0, 0, 2'd0, 4'b0000, 4'd2, 0);
    step(4'b0100, 0, 0, 1, 2'd3, 4'b0100, 4'd2, 0);
    step(4'b0100, 1, 0, 0, 2'd0, 4'b0000, 4'd2, 0);
    // Seven samples then a decode locks; clr_err in SYNC has no effect.
    for (int i = 1; i <= 7; i++) step(4'b0010, (i == 4), 0, 0, 2'd0, 4'b0000, 4'd2, 0);
    step(4'b1000, 0, 1, 0, 2'd0, 4'b0000, 4'd2, 1);
    // clr_err in LOCKED has no effect.
    step(4'b0100, 1, 1, 0, 2'd0, 4'b0000, 4'd2, 0);
    step(4'b0010, 0, 1, 0, 2'd0, 4'b0000, 4'd2, 0);
    step(4'b0001, 0, 1, 0, 2'd0, 4'b0000, 4'd3, 0);

    // Sixteen rotations: 4-bit counter wraps 15 -> 0 with no error.
    c = 4'd3;
    for (int r = 0; r < 16; r++) begin
      step(4'b1000, 0, 1, 0, 2'd0, 4'b0000, c, 1);
      step(4'b0100, 0, 1, 0, 2'd0, 4'b0000, c, 0);
      step(4'b0010, 0, 1, 0, 2'd0, 4'b0000, c, 0);
      c = c + 4'd1;
      step(4'b0001, 0, 1, 0, 2'd0, 4'b0000, c, 0);
    end

    // Asynchronous reset mid-rotation.
    step(4'b1000, 0, 1, 0, 2'd0, 4'b0000, 4'd3, 1);
    step(4'b0100, 0, 1, 0, 2'd0, 4'b0000, 4'd3, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    compare("async_reset", actual(), mk(0, 0, 2'd0, 4'b0000, 4'd0, 0));
    pv = 4'b1000;
    @(negedge clk);
    rst = 1'b1;
    q.push_back(mk(1, 0, 2'd0, 4'b0000, 4'd0, 1));
    step(4'b0100, 0, 1, 0, 2'd0, 4'b0000, 4'd0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
